// File: rtl/game_pkg.sv
// Shared game definitions: scheduler state, enemy queue entry layout,
// slot count and the 56-bit enemy instance record layout.
package game_pkg;

  localparam int unsigned QUEUE_DEPTH = 64;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned SLOT_N      = 8;
  localparam int unsigned SLOT_W      = $clog2(SLOT_N);
  localparam int unsigned ROM_LAT     = 2;
  localparam int unsigned CNT_W       = $clog2(ROM_LAT + 1);
  localparam int unsigned TIME_W      = 12;
  localparam int unsigned TYPE_W      = 3;
  localparam int unsigned ENTRY_W     = 15;

  // Queue entry layout: {timestamp[11:0], type[2:0]}
  localparam int unsigned TS_MSB   = 14;
  localparam int unsigned TS_LSB   = 3;
  localparam int unsigned TYPE_MSB = 2;

  localparam logic [TYPE_W-1:0] ENEMY_TYPE_END = 3'b111;
  localparam logic [TIME_W-1:0] TIME_MAX       = 12'hFFF;

  // Enemy instance record layout as written by the engine
  localparam int unsigned INST_W         = 56;
  localparam int unsigned INST_EXIST_BIT = 55;
  localparam int unsigned INST_TYPE_MSB  = 54;
  localparam int unsigned INST_TYPE_LSB  = 52;
  localparam int unsigned INST_X_MSB     = 51;
  localparam int unsigned INST_X_LSB     = 42;
  localparam int unsigned INST_Y_MSB     = 41;
  localparam int unsigned INST_Y_LSB     = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_TIME,
    S_FIND_SLOT,
    S_SPAWN,
    S_DONE
  } sched_state_t;

  // Spawn request payload handed to the instance writer
  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [TYPE_W-1:0] etype;
  } spawn_req_t;

endpackage

// File: rtl/free_slot_encoder.sv
// Lowest-zero priority encoder over the instance exist bits.
//   i_slot_busy : exist bit per slot
//   o_found_c   : at least one slot is free
//   o_idx_c     : index of the lowest free slot (0 when none)
module free_slot_encoder
  import game_pkg::*;
#(
  parameter int unsigned N     = SLOT_N,
  parameter int unsigned IDX_W = SLOT_W
) (
  input  logic [N-1:0]     i_slot_busy,
  output logic             o_found_c,
  output logic [IDX_W-1:0] o_idx_c
);

  // First free slot scanning upward wins
  always_comb begin
    o_found_c = 1'b0;
    o_idx_c   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!o_found_c && !i_slot_busy[i]) begin
        o_found_c = 1'b1;
        o_idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Enemy wave scheduler: walks the active level's enemy queue ROM, waits
// for game time to reach each entry's timestamp, allocates the lowest free
// instance slot and issues a spawn request to the instance writer.
//   clk_25MHz, rst      : clock, async active-low reset
//   frame_tick          : one pulse per frame, advances game_time
//   start / abort       : level (re)start pulse / forced return to IDLE
//   level               : queue select, sampled on start (0 means 1)
//   slot_busy           : per-slot exist bits
//   rom_sel/addr/data   : queue ROM interface (ROM_LAT cycle read)
//   spawn_valid/slot/type, spawn_ack : spawn handshake
//   game_time, queue_done, busy      : status
module enemy_wave_scheduler
  import game_pkg::*;
(
  input  logic               clk_25MHz,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         level,
  input  logic [SLOT_N-1:0]  slot_busy,
  output logic [1:0]         rom_sel,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [ENTRY_W-1:0] rom_data,
  output logic               spawn_valid,
  output logic [SLOT_W-1:0]  spawn_slot,
  output logic [TYPE_W-1:0]  spawn_type,
  input  logic               spawn_ack,
  output logic [TIME_W-1:0]  game_time,
  output logic               queue_done,
  output logic               busy
);

  sched_state_t        r_state,       w_state_nxt;
  logic [1:0]          r_rom_sel,     w_rom_sel_nxt;
  logic [ADDR_W-1:0]   r_rom_addr,    w_rom_addr_nxt;
  spawn_req_t          r_spawn,       w_spawn_nxt;
  logic                r_spawn_valid, w_spawn_valid_nxt;
  logic [TIME_W-1:0]   r_game_time,   w_game_time_nxt;
  logic                r_queue_done,  w_queue_done_nxt;
  logic                r_busy,        w_busy_nxt;
  logic [TIME_W-1:0]   r_ts,          w_ts_nxt;
  logic [TYPE_W-1:0]   r_type,        w_type_nxt;
  logic [CNT_W-1:0]    r_fetch_cnt,   w_fetch_cnt_nxt;

  logic                w_found;
  logic [SLOT_W-1:0]   w_free_idx;
  logic [TIME_W-1:0]   w_rom_ts;
  logic [TYPE_W-1:0]   w_rom_type;

  assign w_rom_ts   = rom_data[TS_MSB:TS_LSB];
  assign w_rom_type = rom_data[TYPE_MSB:0];

  free_slot_encoder #(
    .N     (SLOT_N),
    .IDX_W (SLOT_W)
  ) u_free_slot (
    .i_slot_busy (slot_busy),
    .o_found_c   (w_found),
    .o_idx_c     (w_free_idx)
  );

  // State and output registers
  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_rom_sel     <= '0;
      r_rom_addr    <= '0;
      r_spawn       <= '0;
      r_spawn_valid <= 1'b0;
      r_game_time   <= '0;
      r_queue_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_ts          <= '0;
      r_type        <= '0;
      r_fetch_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rom_sel     <= w_rom_sel_nxt;
      r_rom_addr    <= w_rom_addr_nxt;
      r_spawn       <= w_spawn_nxt;
      r_spawn_valid <= w_spawn_valid_nxt;
      r_game_time   <= w_game_time_nxt;
      r_queue_done  <= w_queue_done_nxt;
      r_busy        <= w_busy_nxt;
      r_ts          <= w_ts_nxt;
      r_type        <= w_type_nxt;
      r_fetch_cnt   <= w_fetch_cnt_nxt;
    end
  end

  // Next-state and next-output logic; abort beats start beats everything else
  always_comb begin
    w_state_nxt       = r_state;
    w_rom_sel_nxt     = r_rom_sel;
    w_rom_addr_nxt    = r_rom_addr;
    w_spawn_nxt       = r_spawn;
    w_spawn_valid_nxt = r_spawn_valid;
    w_game_time_nxt   = r_game_time;
    w_ts_nxt          = r_ts;
    w_type_nxt        = r_type;
    w_fetch_cnt_nxt   = '0;

    // Game time runs in every state but IDLE and never wraps
    if ((r_state != S_IDLE) && frame_tick && (r_game_time != TIME_MAX)) begin
      w_game_time_nxt = r_game_time + TIME_W'(1);
    end

    if (abort) begin
      w_state_nxt       = S_IDLE;
      w_spawn_valid_nxt = 1'b0;
      w_game_time_nxt   = r_game_time;
    end else if (start) begin
      w_state_nxt       = S_FETCH;
      w_rom_sel_nxt     = (level == 2'd0) ? 2'd1 : level;
      w_rom_addr_nxt    = '0;
      w_game_time_nxt   = '0;
      w_spawn_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Address has been stable ROM_LAT cycles: data is valid now
          if (r_fetch_cnt == CNT_W'(ROM_LAT)) begin
            w_ts_nxt    = w_rom_ts;
            w_type_nxt  = w_rom_type;
            w_state_nxt = (w_rom_type == ENEMY_TYPE_END) ? S_DONE : S_WAIT_TIME;
          end else begin
            w_fetch_cnt_nxt = r_fetch_cnt + CNT_W'(1);
          end
        end
        S_WAIT_TIME: begin
          if (r_game_time >= r_ts) begin
            w_state_nxt = S_FIND_SLOT;
          end
        end
        S_FIND_SLOT: begin
          if (w_found) begin
            w_spawn_nxt.slot  = w_free_idx;
            w_spawn_nxt.etype = r_type;
            w_spawn_valid_nxt = 1'b1;
            w_state_nxt       = S_SPAWN;
          end
        end
        S_SPAWN: begin
          if (spawn_ack) begin
            w_spawn_valid_nxt = 1'b0;
            if (r_rom_addr == ADDR_W'(QUEUE_DEPTH - 1)) begin
              w_state_nxt = S_DONE;
            end else begin
              w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
              w_state_nxt    = S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end

    w_queue_done_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt       = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
  end

  assign rom_sel     = r_rom_sel;
  assign rom_addr    = r_rom_addr;
  assign spawn_valid = r_spawn_valid;
  assign spawn_slot  = r_spawn.slot;
  assign spawn_type  = r_spawn.etype;
  assign game_time   = r_game_time;
  assign queue_done  = r_queue_done;
  assign busy        = r_busy;

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Self-checking bench for enemy_wave_scheduler: random enemy queues with a
// scoreboard of expected spawns, an engine model that marks slots busy on
// ack, and directed cases for allocation, back-pressure, abort and time.
`timescale 1ns/1ps
module tb_enemy_wave_scheduler;

  logic        clk_25MHz = 1'b0;
  logic        rst;
  logic        frame_tick = 1'b0;
  logic        start;
  logic        abort;
  logic [1:0]  level;
  logic [7:0]  slot_busy;
  logic [1:0]  rom_sel;
  logic [5:0]  rom_addr;
  logic [14:0] rom_data;
  logic        spawn_valid;
  logic [2:0]  spawn_slot;
  logic [2:0]  spawn_type;
  logic        spawn_ack = 1'b0;
  logic [11:0] game_time;
  logic        queue_done;
  logic        busy;

  enemy_wave_scheduler dut (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .abort       (abort),
    .level       (level),
    .slot_busy   (slot_busy),
    .rom_sel     (rom_sel),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .spawn_valid (spawn_valid),
    .spawn_slot  (spawn_slot),
    .spawn_type  (spawn_type),
    .spawn_ack   (spawn_ack),
    .game_time   (game_time),
    .queue_done  (queue_done),
    .busy        (busy)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct {
    int slot;
    int typ;
    int ts;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stimulus-owned controls
  logic       force_en  = 1'b0;
  logic [7:0] force_val = 8'h00;
  logic       ack_block = 1'b0;
  int         ack_pct   = 100;
  logic       tick_en   = 1'b0;
  int         tick_period = 4;
  int         ent_ts[$];
  int         ent_ty[$];

  // Engine-owned state
  logic [7:0] eng_mask = 8'h00;
  logic [2:0] ack_slot = 3'd0;

  assign slot_busy = force_en ? force_val : eng_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue ROM, two-cycle read latency from the registered address
  logic [14:0] rom_mem [0:3][0:63];
  logic [14:0] rom_p1, rom_p2;
  always @(posedge clk_25MHz) begin
    rom_p1 <= rom_mem[rom_sel][rom_addr];
    rom_p2 <= rom_p1;
  end
  assign rom_data = rom_p2;

  // Frame tick generator
  int cyc = 0;
  always @(negedge clk_25MHz) begin
    cyc++;
    frame_tick = tick_en && ((cyc % tick_period) == 0);
  end

  // Expected game time: frames since start while a level is active
  int exp_gt  = 0;
  bit running = 0;
  always @(posedge clk_25MHz) begin
    if (!rst) begin
      exp_gt  = 0;
      running = 0;
    end else if (abort) begin
      running = 0;
    end else if (start) begin
      running = 1;
      exp_gt  = 0;
    end else if (running && frame_tick && exp_gt < 4095) begin
      exp_gt++;
    end
  end

  // Engine: random ack latency, marks the acked slot busy; a full wave clears
  always @(posedge clk_25MHz) begin
    #2;
    if (!rst) begin
      eng_mask  = 8'h00;
      spawn_ack = 1'b0;
    end else if (spawn_ack) begin
      eng_mask  = eng_mask | (8'd1 << ack_slot);
      if (eng_mask == 8'hFF) eng_mask = 8'h00;
      spawn_ack = 1'b0;
    end else if (spawn_valid && !ack_block && (int'($urandom_range(0, 99)) < ack_pct)) begin
      spawn_ack = 1'b1;
      ack_slot  = spawn_slot;
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold and time
  bit         prev_valid = 0;
  logic [2:0] prev_slot, prev_type;
  logic [5:0] prev_addr;
  always @(negedge clk_25MHz) begin
    if (!rst) begin
      prev_valid = 0;
    end else begin
      check("game_time", 32'(game_time), 32'(exp_gt));
      if (spawn_valid) begin
        if (prev_valid) begin
          check("hold_slot", 32'(spawn_slot), 32'(prev_slot));
          check("hold_type", 32'(spawn_type), 32'(prev_type));
          check("hold_addr", 32'(rom_addr), 32'(prev_addr));
        end
        if (spawn_ack) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_spawn: slot %0d type %0d with no spawn pending", spawn_slot, spawn_type);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("spawn_slot", 32'(spawn_slot), 32'(e.slot));
            check("spawn_type", 32'(spawn_type), 32'(e.typ));
            check("spawn_not_early", 32'(int'(game_time) >= e.ts), 32'd1);
          end
        end
      end
      prev_valid = spawn_valid && !spawn_ack;
      prev_slot  = spawn_slot;
      prev_type  = spawn_type;
      prev_addr  = rom_addr;
    end
  end

  function automatic int lowest_free(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (!m[i]) return i;
    return -1;
  endfunction

  task automatic pulse_start(input logic [1:0] lvl);
    @(negedge clk_25MHz);
    level = lvl;
    start = 1'b1;
    @(negedge clk_25MHz);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk_25MHz);
    abort = 1'b1;
    @(negedge clk_25MHz);
    abort = 1'b0;
  endtask

  // Load the entry list into the level's ROM, predict spawns, start the level
  task automatic launch(input logic [1:0] lvl, input bit predict);
    int         r;
    logic [7:0] m;
    r = (lvl == 2'd0) ? 1 : int'(lvl);
    for (int i = 0; i < 64; i++) begin
      if (i < ent_ts.size()) rom_mem[r][i] = {12'(ent_ts[i]), 3'(ent_ty[i])};
      else                   rom_mem[r][i] = {12'd0, 3'b111};
    end
    if (predict) begin
      m = force_en ? force_val : eng_mask;
      for (int i = 0; i < 64 && i < ent_ts.size(); i++) begin
        int s;
        if (ent_ty[i] == 7) break;
        s = lowest_free(m);
        sb.push_back('{slot: s, typ: ent_ty[i], ts: ent_ts[i]});
        if (!force_en) begin
          m = m | (8'd1 << s);
          if (m == 8'hFF) m = 8'h00;
        end
      end
    end
    pulse_start(lvl);
    check("start_rom_sel", 32'(rom_sel), 32'(r));
    check("start_rom_addr", 32'(rom_addr), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_queue_done", 32'(queue_done), 32'd0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!spawn_valid && n < budget) begin
      @(negedge clk_25MHz);
      n++;
    end
    check(name, 32'(spawn_valid), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!(queue_done && sb.size() == 0) && n < budget) begin
      @(negedge clk_25MHz);
      n++;
    end
    check({name, "_queue_done"}, 32'(queue_done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_all_spawned"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rom_sel"}, 32'(rom_sel), 32'd0);
    check({name, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({name, "_spawn_valid"}, 32'(spawn_valid), 32'd0);
    check({name, "_spawn_slot"}, 32'(spawn_slot), 32'd0);
    check({name, "_spawn_type"}, 32'(spawn_type), 32'd0);
    check({name, "_game_time"}, 32'(game_time), 32'd0);
    check({name, "_queue_done"}, 32'(queue_done), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #(40 * 80000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  h_slot, h_type;
    logic [5:0]  a0;
    logic [11:0] gt_hold;
    int          n;

    rst = 1'b1; start = 1'b0; abort = 1'b0; level = 2'd0;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 64; i++) rom_mem[l][i] = {12'd0, 3'b111};
    #5 rst = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    check_all_zero("reset");
    @(posedge clk_25MHz); #3 rst = 1'b1;
    tick_en = 1'b1;

    // Same-timestamp burst from an empty instance array: slots 0,1,2
    tick_period = 3; ack_pct = 100;
    ent_ts = '{0, 0, 0}; ent_ty = '{1, 2, 3};
    launch(2'd1, 1);
    wait_done(300, "burst");

    // Timed spawn at ts=3 on a clean slot map
    force_en = 1'b1; force_val = 8'h00; tick_period = 8;
    ent_ts = '{3}; ent_ty = '{1};
    launch(2'd3, 1);
    wait_valid(200, "timed_valid");
    check("timed_game_time_at_valid", 32'(game_time), 32'd3);
    wait_done(200, "timed");

    // Allocation past busy slots 0..2
    force_val = 8'h07; tick_period = 2;
    ent_ts = '{0}; ent_ty = '{2};
    launch(2'd2, 1);
    wait_done(200, "alloc3");

    // All slots busy: stall in FIND_SLOT until slot 5 frees
    force_val = 8'hFF;
    ent_ts = '{0}; ent_ty = '{4};
    launch(2'd1, 0);
    sb.push_back('{slot: 5, typ: 4, ts: 0});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_25MHz);
      check("full_no_valid", 32'(spawn_valid), 32'd0);
    end
    check("full_busy", 32'(busy), 32'd1);
    check("full_addr", 32'(rom_addr), 32'd0);
    force_val = 8'hDF;
    n = 0;
    while (!spawn_valid && n < 2) begin
      @(negedge clk_25MHz);
      n++;
    end
    check("free5_valid", 32'(spawn_valid), 32'd1);
    check("free5_slot", 32'(spawn_slot), 32'd5);
    wait_done(200, "free5");
    force_en = 1'b0;

    // Back-pressure: ack withheld for 10 cycles
    ack_block = 1'b1;
    ent_ts = '{0, 0}; ent_ty = '{6, 5};
    launch(2'd1, 1);
    wait_valid(100, "bp_valid");
    h_slot = spawn_slot; h_type = spawn_type; a0 = rom_addr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_25MHz);
      check("bp_valid_held", 32'(spawn_valid), 32'd1);
      check("bp_slot_held", 32'(spawn_slot), 32'(h_slot));
      check("bp_type_held", 32'(spawn_type), 32'(h_type));
      check("bp_addr_held", 32'(rom_addr), 32'(a0));
    end
    ack_block = 1'b0;
    n = 0;
    while (rom_addr == a0 && n < 6) begin
      @(negedge clk_25MHz);
      n++;
    end
    check("bp_addr_incr", 32'(rom_addr), 32'(a0) + 32'd1);
    wait_done(300, "bp");

    // Abort during WAIT_TIME, game time frozen afterwards
    tick_period = 2;
    ent_ts = '{4000}; ent_ty = '{1};
    launch(2'd2, 1);
    repeat (10) @(negedge clk_25MHz);
    check("wait_busy", 32'(busy), 32'd1);
    pulse_abort();
    sb.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(spawn_valid), 32'd0);
    gt_hold = game_time;
    repeat (6) @(negedge clk_25MHz);
    check("abort_time_held", 32'(game_time), 32'(gt_hold));

    // start and abort together: abort wins
    launch(2'd2, 0);
    repeat (3) @(negedge clk_25MHz);
    @(negedge clk_25MHz);
    start = 1'b1; abort = 1'b1; level = 2'd3;
    @(negedge clk_25MHz);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_valid", 32'(spawn_valid), 32'd0);

    // Level 0 maps to level 1; saturation of game time in DONE
    ent_ts = {}; ent_ty = {};
    launch(2'd0, 1);
    wait_done(50, "empty");
    tick_period = 1;
    repeat (4100) @(negedge clk_25MHz);
    check("sat_game_time", 32'(game_time), 32'd4095);
    check("sat_queue_done", 32'(queue_done), 32'd1);

    // 64 entries without a sentinel: DONE after the last one
    tick_period = 2; ack_pct = 60;
    ent_ts = {}; ent_ty = {};
    for (int i = 0; i < 64; i++) begin
      ent_ts.push_back(int'($urandom_range(0, 5)));
      ent_ty.push_back(int'($urandom_range(0, 6)));
    end
    launch(2'd3, 1);
    wait_done(4000, "full64");
    check("full64_addr", 32'(rom_addr), 32'd63);

    // Random queues: non-monotonic timestamps, random ack latency and level
    for (int r = 0; r < 6; r++) begin
      int len;
      len = int'($urandom_range(1, 12));
      tick_period = int'($urandom_range(1, 3));
      ack_pct = int'($urandom_range(30, 100));
      ent_ts = {}; ent_ty = {};
      for (int i = 0; i < len; i++) begin
        ent_ts.push_back(int'($urandom_range(0, 40)));
        ent_ty.push_back(int'($urandom_range(0, 6)));
      end
      launch(2'($urandom_range(0, 3)), 1);
      wait_done(len * 200 + 500, "random");
    end

    // Reset asserted while a spawn is pending clears every output at once
    ack_block = 1'b1; ack_pct = 100;
    ent_ts = '{0}; ent_ty = '{2};
    launch(2'd1, 1);
    wait_valid(100, "rst_spawn_valid");
    sb.delete();
    @(negedge clk_25MHz);
    #3 rst = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk_25MHz);
    @(posedge clk_25MHz); #3 rst = 1'b1;
    ack_block = 1'b0;
    ent_ts = '{0}; ent_ty = '{1};
    launch(2'd2, 1);
    check("restart_game_time", 32'(game_time), 32'd0);
    wait_done(200, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_wave_scheduler.md
Name: enemy_wave_scheduler

Overview:
- Sequences enemy spawns for the active level.
- Walks the level's enemy queue ROM ({timestamp[11:0], type[2:0]}, 15b/entry) and waits until game time reaches each entry's timestamp.
- Allocates the lowest free enemy instance slot and hands a spawn request to the Game_Engine instance writer.
- Sits between the scene FSM (start/abort), the per-level enemy queue ROMs and the Enemy_Instance array.

Parameters:
QUEUE_DEPTH, 64, entries per level queue
ADDR_W, 6, queue address width (log2 QUEUE_DEPTH)
SLOT_N, 8, enemy instance slots
ROM_LAT, 2, queue ROM read latency in cycles (registered address to valid data)

Ports:
clk_25MHz  in  1  system clock
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame, synchronous to clk_25MHz
start  in  1  one-cycle pulse: begin or restart level (gameInit)
abort  in  1  level: scene left PLAY; force IDLE
level  in  2  1..3 selects queue; sampled only on start
slot_busy  in  SLOT_N  exist bits of Enemy_Instance[i][55]
rom_sel  out  2  queue ROM select (registered level)
rom_addr  out  ADDR_W  queue ROM address
rom_data  in  15  {ts[14:3], type[2:0]}
spawn_valid  out  1  spawn request
spawn_slot  out  3  target slot
spawn_type  out  3  enemy type
spawn_ack  in  1  instance write committed this cycle
game_time  out  12  frames since start, saturating
queue_done  out  1  queue exhausted
busy  out  1  state not IDLE/DONE

Behaviour:
- Reset (rst=0, async): state IDLE; rom_sel=0, rom_addr=0, spawn_valid=0, spawn_slot=0, spawn_type=0, game_time=0, queue_done=0, busy=0. All outputs registered.
- States: IDLE, FETCH, WAIT_TIME, FIND_SLOT, SPAWN, DONE.
- IDLE: on start, load rom_sel=level, rom_addr=0, game_time=0, queue_done=0 -> FETCH.
- start in any state: identical restart; takes priority over every other event except abort.
- abort in any state: -> IDLE next cycle; spawn_valid drops; game_time held. If start and abort coincide, abort wins.
- level=0 on start: treated as level 1.
- FETCH: waits ROM_LAT cycles after the address is stable, then latches rom_data into ts_q/type_q.
  - type==3'b111 is the end sentinel -> DONE.
  - Otherwise -> WAIT_TIME.
- WAIT_TIME: when game_time >= ts_q -> FIND_SLOT. A timestamp already in the past spawns without waiting (non-monotonic queues allowed).
- FIND_SLOT: priority-encode the lowest i with slot_busy[i]==0. Evaluation takes 1 cycle.
  - A slot is found: register spawn_slot and spawn_type -> SPAWN.
  - All slots busy: stay in FIND_SLOT and re-evaluate every cycle (back-pressure; queue stalls, time keeps running).
- SPAWN: spawn_valid=1 with spawn_slot/spawn_type stable until spawn_ack.
  - Ack cycle: spawn_valid=0 next cycle.
  - If rom_addr==QUEUE_DEPTH-1 -> DONE; else increment rom_addr -> FETCH.
  - The engine must raise slot_busy for the acked slot within 1 cycle of ack. FETCH lasting >= ROM_LAT+1 cycles guarantees no double allocation.
- DONE: queue_done=1, busy=0. game_time keeps counting; stays until start/abort.
- game_time: +1 on frame_tick in FETCH/WAIT_TIME/FIND_SLOT/SPAWN/DONE; saturates at 4095 (no wrap). Held in IDLE.
- spawn_ack outside SPAWN: ignored.
- Multiple entries with equal ts: spawned back-to-back, one per FETCH/SPAWN round, in queue order.

Decomposition:
- Shared package game_pkg holds:
  - scheduler state enum
  - ENEMY_TYPE_END = 3'b111
  - queue entry field offsets (TS_MSB=14, TS_LSB=3, TYPE_MSB=2)
  - SLOT_N
  - the 56-bit instance field offsets already used by the engine
- One natural sub-module: free_slot_encoder, a combinational lowest-zero priority encoder (slot_busy -> found, index).

Test Plan:
- Reset/start: rst low mid-SPAWN -> all outputs 0 immediately. Release, start with level=2 -> rom_sel=2, rom_addr=0, busy=1, game_time=0.
- Timed spawn: queue {ts=3,type=1},{END}, ack same cycle as valid -> spawn_valid rises only after 3rd frame_tick, spawn_slot=0, spawn_type=1; then queue_done=1.
- Slot allocation: slot_busy=8'b0000_0111 -> spawn_slot=3. slot_busy=8'hFF -> spawn_valid stays 0 and FSM stays in FIND_SLOT; clear bit 5 -> spawn_slot=5 within 2 cycles.
- Back-pressure: withhold spawn_ack 10 cycles -> spawn_valid, slot and type stable all 10 cycles, rom_addr unchanged; ack -> rom_addr increments.
- Same-timestamp burst: three entries ts=0, types 1,2,3, engine sets busy on ack -> slots 0,1,2 in order, no slot reused.
- Abort/restart/saturation: abort during WAIT_TIME -> IDLE, spawn_valid=0. start+abort same cycle -> IDLE. 4100 frame_ticks in DONE -> game_time=4095. 64 non-sentinel entries -> DONE after entry 63.
